// File: rtl/ram_mailbox_scalar_mul.sv
// ram_mailbox_scalar_mul
//   Dual-port operand RAM plus command/status mailbox for the scalar-mul core.
//   Port A (host) loads operands, issues a command by writing CMD_ADDR and
//   collects the result by reading STAT_ADDR. Port B (datapath) sees the same
//   RAM. A four-state handshake FSM (IDLE/PEND/RUN/DONE) tracks the command.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   a_w/a_adbus/a_data_in    port A write enable, address, write data
//   a_data_out               port A read data (1-cycle latency, read-first)
//   b_*                      port B equivalents
//   command, cmd_valid       latched command word, pending-command flag
//   cmd_ready                core accepts the pending command
//   done, status             core completion pulse and its status word
//   busy, irq, err           PEND|RUN, result available, sticky protocol error
//
// Configuration
//   RAM_MAILBOX_WP_EN  when defined, port A RAM writes while busy are dropped
//                      and set err.
module ram_mailbox_scalar_mul #(
    parameter int DATA      = 256,
    parameter int ADDR_W    = 6,
    parameter int CMD_ADDR  = (2**ADDR_W) - 1,
    parameter int STAT_ADDR = (2**ADDR_W) - 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_w,
    input  logic [ADDR_W-1:0] a_adbus,
    input  logic [DATA-1:0]   a_data_in,
    output logic [DATA-1:0]   a_data_out,
    input  logic              b_w,
    input  logic [ADDR_W-1:0] b_adbus,
    input  logic [DATA-1:0]   b_data_in,
    output logic [DATA-1:0]   b_data_out,
    output logic [DATA-1:0]   command,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    input  logic              done,
    input  logic [DATA-1:0]   status,
    output logic              busy,
    output logic              irq,
    output logic              err
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] CMD_A  = CMD_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] STAT_A = STAT_ADDR[ADDR_W-1:0];

    typedef enum logic [1:0] {IDLE, PEND, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [DATA-1:0]   status_q;
    logic [DATA-1:0]   mem [DEPTH];

    logic a_is_cmd, a_is_stat, b_is_cmd, b_is_stat;
    logic a_cmd_wr, a_stat_wr, a_stat_rd;
    logic a_ram_we, b_ram_we;
    logic err_set, err_clr;

    assign a_is_cmd  = (a_adbus == CMD_A);
    assign a_is_stat = (a_adbus == STAT_A);
    assign b_is_cmd  = (b_adbus == CMD_A);
    assign b_is_stat = (b_adbus == STAT_A);

    assign a_cmd_wr  = a_w && a_is_cmd;
    assign a_stat_wr = a_w && a_is_stat;
    assign a_stat_rd = !a_w && a_is_stat;

    assign cmd_valid = (state_q == PEND);
    assign busy      = (state_q == PEND) || (state_q == RUN);
    assign irq       = (state_q == DONE);

`ifdef RAM_MAILBOX_WP_EN
    // Host may not disturb operands while the core owns them.
    assign a_ram_we = a_w && !a_is_cmd && !a_is_stat && !busy;
    assign err_set  = (a_cmd_wr && state_q != IDLE) ||
                      (a_w && !a_is_cmd && !a_is_stat && busy);
`else
    assign a_ram_we = a_w && !a_is_cmd && !a_is_stat;
    assign err_set  = a_cmd_wr && (state_q != IDLE);
`endif
    // Port B writes to the register addresses fall on the floor.
    assign b_ram_we = b_w && !b_is_cmd && !b_is_stat;
    assign err_clr  = a_stat_wr;

    // NOTE: the RAM array is deliberately not reset; only registers with a
    // defined reset value go through the rst branch.
    // Port B's assignment comes last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (a_ram_we) mem[a_adbus] <= a_data_in;
        if (b_ram_we) mem[b_adbus] <= b_data_in;
    end

    // NOTE: sequential state uses non-blocking assignments so every read in
    // this edge sees pre-edge values; that is what gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_data_out <= '0;
            b_data_out <= '0;
        end else begin
            if (a_is_cmd)       a_data_out <= command;
            else if (a_is_stat) a_data_out <= status_q;
            else                a_data_out <= mem[a_adbus];

            if (b_is_cmd)       b_data_out <= command;
            else if (b_is_stat) b_data_out <= status_q;
            else                b_data_out <= mem[b_adbus];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            command  <= '0;
            status_q <= '0;
            err      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && a_cmd_wr) command  <= a_data_in;
            if (state_q == RUN && done)      status_q <= status;
            // Set has priority over clear.
            if (err_set)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (a_cmd_wr)  state_d = PEND;
            PEND:    if (cmd_ready) state_d = RUN;
            RUN:     if (done)      state_d = DONE;
            DONE:    if (a_stat_rd) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_mailbox_scalar_mul.sv
// Directed bench for ram_mailbox_scalar_mul. Inputs change just after a
// falling edge; outputs are sampled one falling edge later.
module tb_ram_mailbox_scalar_mul;

    localparam int DATA   = 256;
    localparam int ADDR_W = 6;
    localparam logic [ADDR_W-1:0] CMD  = 6'd63;
    localparam logic [ADDR_W-1:0] STAT = 6'd62;

`ifdef RAM_MAILBOX_WP_EN
    localparam logic            WP_ERR  = 1'b1;
    localparam logic [DATA-1:0] WP_ADDR2 = 256'h11;
`else
    localparam logic            WP_ERR  = 1'b0;
    localparam logic [DATA-1:0] WP_ADDR2 = 256'hFF;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              a_w = 1'b0;
    logic [ADDR_W-1:0] a_adbus = '0;
    logic [DATA-1:0]   a_data_in = '0;
    logic [DATA-1:0]   a_data_out;
    logic              b_w = 1'b0;
    logic [ADDR_W-1:0] b_adbus = '0;
    logic [DATA-1:0]   b_data_in = '0;
    logic [DATA-1:0]   b_data_out;
    logic [DATA-1:0]   command;
    logic              cmd_valid;
    logic              cmd_ready = 1'b0;
    logic              done = 1'b0;
    logic [DATA-1:0]   status = '0;
    logic              busy, irq, err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_mailbox_scalar_mul #(.DATA(DATA), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .a_w(a_w), .a_adbus(a_adbus), .a_data_in(a_data_in), .a_data_out(a_data_out),
        .b_w(b_w), .b_adbus(b_adbus), .b_data_in(b_data_in), .b_data_out(b_data_out),
        .command(command), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .done(done), .status(status),
        .busy(busy), .irq(irq), .err(err)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic a_wr(input logic [ADDR_W-1:0] addr, input logic [DATA-1:0] data);
        a_w = 1'b1; a_adbus = addr; a_data_in = data;
        tick();
        a_w = 1'b0;
    endtask

    task automatic handshake();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
    endtask

    task automatic pulse_done(input logic [DATA-1:0] st);
        done = 1'b1; status = st;
        tick();
        done = 1'b0; status = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_cmd_valid got=%0h want=0", cmd_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h want=0", busy); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%0h want=0", irq); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0h want=0", err); end
        total++; if (command !== '0) begin bad++; $display("FAIL reset_command got=%0h want=0", command); end
        total++; if (a_data_out !== '0) begin bad++; $display("FAIL reset_a_data_out got=%0h want=0", a_data_out); end
        total++; if (b_data_out !== '0) begin bad++; $display("FAIL reset_b_data_out got=%0h want=0", b_data_out); end
        rst = 1'b0;
        a_adbus = STAT;
        tick();
        total++; if (a_data_out !== '0) begin bad++; $display("FAIL reset_status_reg got=%0h want=0", a_data_out); end
    endtask

    task automatic test_ram();
        a_wr(6'd3, 256'h1234);
        b_adbus = 6'd3;
        tick();
        total++; if (b_data_out !== 256'h1234) begin bad++; $display("FAIL ram_b_read got=%0h want=1234", b_data_out); end
        // Overwrite addr 3 from A while both ports read it: both see old data.
        a_w = 1'b1; a_adbus = 6'd3; a_data_in = 256'h55;
        tick();
        a_w = 1'b0;
        total++; if (a_data_out !== 256'h1234) begin bad++; $display("FAIL ram_read_first got=%0h want=1234", a_data_out); end
        total++; if (b_data_out !== 256'h1234) begin bad++; $display("FAIL ram_cross_old got=%0h want=1234", b_data_out); end
        tick();
        total++; if (b_data_out !== 256'h55) begin bad++; $display("FAIL ram_new_data got=%0h want=55", b_data_out); end
    endtask

    task automatic test_collision();
        a_w = 1'b1; a_adbus = 6'd5; a_data_in = 256'hAA;
        b_w = 1'b1; b_adbus = 6'd5; b_data_in = 256'hBB;
        tick();
        a_w = 1'b0; b_w = 1'b0;
        tick();
        total++; if (a_data_out !== 256'hBB) begin bad++; $display("FAIL collision got=%0h want=bb", a_data_out); end
    endtask

    task automatic test_transaction();
        a_wr(CMD, 256'h7);
        total++; if (cmd_valid !== 1'b1) begin bad++; $display("FAIL txn_cmd_valid got=%0h want=1", cmd_valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL txn_busy got=%0h want=1", busy); end
        total++; if (command !== 256'h7) begin bad++; $display("FAIL txn_command got=%0h want=7", command); end
        b_adbus = CMD;
        repeat (3) tick();
        total++; if (cmd_valid !== 1'b1) begin bad++; $display("FAIL txn_hold_valid got=%0h want=1", cmd_valid); end
        total++; if (b_data_out !== 256'h7) begin bad++; $display("FAIL txn_b_read_cmd got=%0h want=7", b_data_out); end
        handshake();
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL txn_valid_drop got=%0h want=0", cmd_valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL txn_run_busy got=%0h want=1", busy); end
        pulse_done(256'h1);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL txn_irq got=%0h want=1", irq); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL txn_done_busy got=%0h want=0", busy); end
        a_adbus = STAT;
        tick();
        total++; if (a_data_out !== 256'h1) begin bad++; $display("FAIL txn_status got=%0h want=1", a_data_out); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL txn_irq_clear got=%0h want=0", irq); end
        // done while IDLE must not touch the status register.
        pulse_done(256'h99);
        tick();
        total++; if (a_data_out !== 256'h1) begin bad++; $display("FAIL idle_done_status got=%0h want=1", a_data_out); end
        total++; if (irq !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL idle_done_flags got=%0h%0h want=00", irq, err); end
    endtask

    task automatic test_cmd_in_run();
        a_wr(6'd2, 256'h11);
        a_wr(CMD, 256'h3);
        handshake();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL run_err_start got=%0h want=0", err); end
        a_wr(CMD, 256'h9);
        total++; if (command !== 256'h3) begin bad++; $display("FAIL run_cmd_kept got=%0h want=3", command); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL run_err_set got=%0h want=1", err); end
        a_wr(STAT, 256'h0);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL run_err_clear got=%0h want=0", err); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL run_still_busy got=%0h want=1", busy); end
        a_wr(6'd2, 256'hFF);
        total++; if (err !== WP_ERR) begin bad++; $display("FAIL wp_err got=%0h want=%0h", err, WP_ERR); end
        a_adbus = 6'd2;
        tick();
        total++; if (a_data_out !== WP_ADDR2) begin bad++; $display("FAIL wp_addr2 got=%0h want=%0h", a_data_out, WP_ADDR2); end
        a_wr(STAT, 256'h0);
        pulse_done(256'h2);
        a_adbus = STAT;
        tick();
        total++; if (a_data_out !== 256'h2 || busy !== 1'b0) begin bad++; $display("FAIL run_finish got=%0h/%0h want=2/0", a_data_out, busy); end
        tick();
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL run_back_idle got=%0h want=0", irq); end
    endtask

    task automatic test_rst_mid();
        a_wr(CMD, 256'h4);
        handshake();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_mid_busy_pre got=%0h want=1", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (busy !== 1'b0 || cmd_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_flags got=%0h%0h want=00", busy, cmd_valid); end
        total++; if (command !== '0) begin bad++; $display("FAIL rst_mid_command got=%0h want=0", command); end
        pulse_done(256'h5);
        total++; if (irq !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid_done got=%0h%0h want=00", irq, busy); end
        a_adbus = STAT;
        tick();
        total++; if (a_data_out !== '0) begin bad++; $display("FAIL rst_mid_status got=%0h want=0", a_data_out); end
    endtask

    initial begin
        tick();
        test_reset();
        test_ram();
        test_collision();
        test_transaction();
        test_cmd_in_run();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
